// File: rtl/shift_ring_counter_if.sv
// shift_ring_counter_if: control and status bundle
// for the ring/Johnson shift counter.
interface shift_ring_counter_if #(
    parameter int WIDTH = 6,
    parameter int PW    = $clog2(2 * WIDTH)
);
    logic             en;
    logic             mode;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [PW-1:0]    pos;
    logic             wrap;
    logic             err;
    logic             err_sticky;

    modport master (
        output en, mode, dir, load, din,
        input  q, qbar, pos, wrap, err, err_sticky
    );

    modport slave (
        input  en, mode, dir, load, din,
        output q, qbar, pos, wrap, err, err_sticky
    );
endinterface

// File: rtl/shift_ring_counter.sv
// shift_ring_counter: ring/Johnson counter with load,
// illegal-state correction, position decode and wrap.
module shift_ring_counter #(
    parameter int WIDTH = 6,
    parameter int PW    = $clog2(2 * WIDTH)
) (
    input logic                 clk,
    input logic                 reset,
    shift_ring_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] RING_HOME = WIDTH'(1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] home;
    logic [WIDTH-1:0] step;
    logic [PW-1:0]    pos;
    logic             wrap;
    logic             err;
    logic             err_sticky;
    logic             ring_ok;
    logic             john_ok;
    logic             legal;
    int               ones;
    int               trans;
    int               ring_idx;

    // Johnson legality counts only linear transitions, so the
    // single run of ones must touch bit 0 or bit WIDTH-1.
    always_comb begin
        ones     = 0;
        trans    = 0;
        ring_idx = 0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + int'(q[i]);
            if (q[i]) ring_idx = i;
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            trans = trans + int'(q[i] ^ q[i+1]);
        end
        ring_ok = (ones == 1);
        john_ok = (trans <= 1);
        legal   = bus.mode ? john_ok : ring_ok;
        home    = bus.mode ? '0 : RING_HOME;
    end

    // One-position shift for the selected mode and direction.
    always_comb begin
        step = q;
        unique case ({bus.mode, bus.dir})
            2'b00: step = {q[WIDTH-2:0], q[WIDTH-1]};
            2'b01: step = {q[0], q[WIDTH-1:1]};
            2'b10: step = {q[WIDTH-2:0], ~q[WIDTH-1]};
            2'b11: step = {~q[0], q[WIDTH-1:1]};
        endcase
    end

    // Position decode; Johnson second half counts down from 2*WIDTH.
    always_comb begin
        pos = '0;
        if (!bus.mode) begin
            if (ring_ok) pos = PW'(ring_idx);
        end else if (ones != 0) begin
            if (q[0]) pos = PW'(ones);
            else      pos = PW'(2 * WIDTH - ones);
        end
    end

    // State register: reset > load > step/correct > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            q          <= home;
            wrap       <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else if (bus.load) begin
            q    <= bus.din;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else if (bus.en) begin
            if (legal) begin
                q    <= step;
                wrap <= (step == home);
                err  <= 1'b0;
            end else begin
                q          <= home;
                wrap       <= 1'b0;
                err        <= 1'b1;
                err_sticky <= 1'b1;
            end
        end else begin
            wrap <= 1'b0;
            err  <= 1'b0;
        end
    end

    assign bus.q          = q;
    assign bus.qbar       = ~q;
    assign bus.pos        = pos;
    assign bus.wrap       = wrap;
    assign bus.err        = err;
    assign bus.err_sticky = err_sticky;
endmodule

// File: tb/tb_shift_ring_counter.sv
// tb_shift_ring_counter: directed checks of ring/Johnson
// stepping, correction, hold and priority behaviour.
module tb_shift_ring_counter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    shift_ring_counter_if #(.WIDTH(6)) bus ();

    shift_ring_counter #(.WIDTH(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] jtab [12] = '{
        6'b000001, 6'b000011, 6'b000111, 6'b001111,
        6'b011111, 6'b111111, 6'b111110, 6'b111100,
        6'b111000, 6'b110000, 6'b100000, 6'b000000
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.mode = 1'b0;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.q !== 6'b000001) begin
            errors++;
            $display("FAIL reset_q: got %b want 000001", bus.q);
        end
        checks++;
        if (bus.qbar !== 6'b111110) begin
            errors++;
            $display("FAIL reset_qbar: got %b want 111110", bus.qbar);
        end
        checks++;
        if ({bus.wrap, bus.err, bus.err_sticky} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000",
                     {bus.wrap, bus.err, bus.err_sticky});
        end
        checks++;
        if (bus.pos !== 4'd0) begin
            errors++;
            $display("FAIL reset_pos: got %0d want 0", bus.pos);
        end
    endtask

    task automatic test_ring_fwd();
        logic [5:0] eq;
        bus.en = 1'b1; bus.mode = 1'b0; bus.dir = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            eq = 6'b000001 << (i % 6);
            checks++;
            if (bus.q !== eq || bus.pos !== 4'(i % 6)) begin
                errors++;
                $display("FAIL ring_fwd[%0d]: got q=%b pos=%0d want q=%b pos=%0d",
                         i, bus.q, bus.pos, eq, i % 6);
            end
            checks++;
            if (bus.wrap !== (i == 6)) begin
                errors++;
                $display("FAIL ring_wrap[%0d]: got %b want %b",
                         i, bus.wrap, (i == 6));
            end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_johnson_fwd();
        reset = 1'b1; bus.mode = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.q !== 6'b000000) begin
            errors++;
            $display("FAIL john_reset: got %b want 000000", bus.q);
        end
        bus.en = 1'b1; bus.dir = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (bus.q !== jtab[i-1] || bus.pos !== 4'(i % 12)) begin
                errors++;
                $display("FAIL john_fwd[%0d]: got q=%b pos=%0d want q=%b pos=%0d",
                         i, bus.q, bus.pos, jtab[i-1], i % 12);
            end
            checks++;
            if (bus.wrap !== (i == 12)) begin
                errors++;
                $display("FAIL john_wrap[%0d]: got %b want %b",
                         i, bus.wrap, (i == 12));
            end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_johnson_rev();
        logic [5:0] eq [6] = '{6'b100000, 6'b110000, 6'b111000,
                               6'b110000, 6'b100000, 6'b000000};
        logic [3:0] ep [6] = '{4'd11, 4'd10, 4'd9, 4'd10, 4'd11, 4'd0};
        bus.en = 1'b1; bus.mode = 1'b1; bus.dir = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) bus.dir = 1'b0;
            tick();
            checks++;
            if (bus.q !== eq[i] || bus.pos !== ep[i] || bus.wrap !== (i == 5)) begin
                errors++;
                $display("FAIL john_rev[%0d]: got q=%b pos=%0d wrap=%b want q=%b pos=%0d wrap=%b",
                         i, bus.q, bus.pos, bus.wrap, eq[i], ep[i], (i == 5));
            end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_illegal_load();
        bus.mode = 1'b0; bus.en = 1'b0;
        bus.load = 1'b1; bus.din = 6'b000101;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.q !== 6'b000101 || bus.pos !== 4'd0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL load_raw: got q=%b pos=%0d err=%b want 000101 0 0",
                     bus.q, bus.pos, bus.err);
        end
        bus.en = 1'b1;
        tick();
        checks++;
        if (bus.q !== 6'b000001 || bus.err !== 1'b1 ||
            bus.err_sticky !== 1'b1 || bus.wrap !== 1'b0) begin
            errors++;
            $display("FAIL ring_correct: got q=%b err=%b sticky=%b wrap=%b want 000001 1 1 0",
                     bus.q, bus.err, bus.err_sticky, bus.wrap);
        end
        tick();
        checks++;
        if (bus.q !== 6'b000010 || bus.err !== 1'b0 || bus.err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL after_correct: got q=%b err=%b sticky=%b want 000010 0 1",
                     bus.q, bus.err, bus.err_sticky);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_mode_switch();
        bus.mode = 1'b1; bus.dir = 1'b0;
        bus.load = 1'b1; bus.din = 6'b000011;
        tick();
        bus.load = 1'b0; bus.en = 1'b1;
        tick();
        checks++;
        if (bus.q !== 6'b000111 || bus.pos !== 4'd3) begin
            errors++;
            $display("FAIL john_run: got q=%b pos=%0d want 000111 3",
                     bus.q, bus.pos);
        end
        bus.mode = 1'b0;
        tick();
        checks++;
        if (bus.q !== 6'b000001 || bus.err !== 1'b1 || bus.wrap !== 1'b0) begin
            errors++;
            $display("FAIL mode_correct: got q=%b err=%b wrap=%b want 000001 1 0",
                     bus.q, bus.err, bus.wrap);
        end
        tick();
        checks++;
        if (bus.q !== 6'b000010 || bus.err !== 1'b0 || bus.pos !== 4'd1) begin
            errors++;
            $display("FAIL ring_resume: got q=%b err=%b pos=%0d want 000010 0 1",
                     bus.q, bus.err, bus.pos);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_hold();
        bus.mode = 1'b0; bus.dir = 1'b0; bus.en = 1'b1;
        repeat (5) tick();
        checks++;
        if (bus.q !== 6'b000001 || bus.wrap !== 1'b1) begin
            errors++;
            $display("FAIL pre_hold: got q=%b wrap=%b want 000001 1",
                     bus.q, bus.wrap);
        end
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.q !== 6'b000001 || bus.pos !== 4'd0 || bus.wrap !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: got q=%b pos=%0d wrap=%b want 000001 0 0",
                         i, bus.q, bus.pos, bus.wrap);
            end
        end
    endtask

    task automatic test_load_priority();
        bus.mode = 1'b0; bus.dir = 1'b0;
        bus.en = 1'b1; bus.load = 1'b1; bus.din = 6'b000100;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.q !== 6'b000100 || bus.pos !== 4'd2) begin
            errors++;
            $display("FAIL load_over_en: got q=%b pos=%0d want 000100 2",
                     bus.q, bus.pos);
        end
        tick();
        checks++;
        if (bus.q !== 6'b001000) begin
            errors++;
            $display("FAIL step_after_load: got %b want 001000", bus.q);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_reset_priority();
        bus.mode = 1'b1; bus.en = 1'b1;
        bus.load = 1'b1; bus.din = 6'b101010;
        reset = 1'b1;
        tick();
        checks++;
        if (bus.q !== 6'b000000 ||
            {bus.wrap, bus.err, bus.err_sticky} !== 3'b000) begin
            errors++;
            $display("FAIL reset_john: got q=%b flags=%b want 000000 000",
                     bus.q, {bus.wrap, bus.err, bus.err_sticky});
        end
        bus.mode = 1'b0;
        tick();
        checks++;
        if (bus.q !== 6'b000001) begin
            errors++;
            $display("FAIL reset_ring: got %b want 000001", bus.q);
        end
        reset = 1'b0; bus.load = 1'b0; bus.en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.en = 1'b0; bus.mode = 1'b0; bus.dir = 1'b0;
        bus.load = 1'b0; bus.din = '0;
        test_reset();
        test_ring_fwd();
        test_johnson_fwd();
        test_johnson_rev();
        test_illegal_load();
        test_mode_switch();
        test_hold();
        test_load_priority();
        test_reset_priority();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
